rgmii_tx_adapter: RTL and testbench
===================================

# rgmii_tx_adapter

Transmit-side RGMII formatter, the counterpart of the receive-side 100M/1000M speed detector. It accepts a byte stream from the MAC in the 125 MHz `sys_clk` domain and drives DDR-register inputs (high/low half of each cycle) for TXD, TX_CTL and TXC. Output format follows the detected `SPEED_IS_100_1000` (1 = 100M, 0 = 1000M). The block enforces the minimum inter-frame gap and handles MAC underrun.

## Interface
Parameters:
- `SLOT_100`, 10: sys_clk cycles per byte at 100M (two 25 MHz periods).
- `IFG_BYTES`, 12: idle byte slots inserted after every frame.

Ports:
- `sys_clk`  in  1  125 MHz clock. Single clock for the whole block.
- `sys_rst_n`  in  1  Reset, asynchronous, active-low.
- `SPEED_IS_100_1000`  in  1  Speed select, 1 = 100M, 0 = 1000M. Same `sys_clk` domain as this block; no synchroniser.
- `tx_data`  in  8  Frame byte, preamble/SFD included by the MAC.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_eop`  in  1  Marks the last byte of the frame; qualified by `tx_valid`.
- `tx_ready`  out  1  Byte accepted when `tx_valid & tx_ready`.
- `txd_h`, `txd_l`  out  4 each  TXD for the rising and falling half of the cycle.
- `txctl_h`, `txctl_l`  out  1 each  `txctl_h` = TX_EN; `txctl_l` = TX_EN ^ TX_ER.
- `txc_h`, `txc_l`  out  1 each  TXC pattern for the DDR output.
- `tx_underrun`  out  1  One-cycle pulse when an underrun is detected.

## Operation
- **Speed latch.** `speed_q` samples `SPEED_IS_100_1000` only in IDLE, at a slot end.
  - A change of value restarts the phase counter at 0.
  - Changes during a frame or IFG are ignored until the next IDLE slot end.
- **Phase counter.**
  - 100M: counts 0..9 and wraps.
  - 1000M: held at 0.
  - `slot_end` = (phase == 9) in 100M, constant 1 in 1000M.
- **TXC.**
  - 1000M: `txc_h`=1, `txc_l`=0 every cycle.
  - 100M, (h,l) per phase 0..4: (1,1),(1,1),(1,0),(0,0),(0,0); phases 5..9 repeat the same pattern.
- **Handshake.** `tx_ready` = `slot_end` && state ∈ {IDLE, DATA, DROP}.
- **State machine:**
  - IDLE: on an accepted byte, load the byte register and go to DATA; go straight to IFG if `tx_eop` is set.
  - DATA:
    - At `slot_end` with `tx_valid`=1, accept the next byte.
    - If that byte carries `tx_eop`=1, go to IFG after its slot.
    - At `slot_end` with `tx_valid`=0: pulse `tx_underrun` and go to ERR.
  - ERR: transmit one byte slot with TX_EN=1, TX_ER=1, TXD=0, then go to DROP.
  - DROP: bytes are accepted and discarded until an accepted `tx_eop`, then go to IFG.
  - IFG: `IFG_BYTES` slots with TX_EN=0 and TXD=0, then go to IDLE.
- **Data mapping:**
  - 1000M: `txd_h`=byte[3:0], `txd_l`=byte[7:4].
  - 100M, phases 0..4: `txd_h`=`txd_l`=byte[3:0].
  - 100M, phases 5..9: `txd_h`=`txd_l`=byte[7:4].
  - When not transmitting, TXD=0 and TX_CTL=0.

## Timing
- All outputs are registered.
- A byte accepted in cycle N appears on `txd_*` and `txctl_*` in cycle N+1.
  - 1000M: it occupies one cycle.
  - 100M: it occupies cycles N+1..N+10 (low nibble N+1..N+5, high nibble N+6..N+10).
- Back-to-back 1000M frames: the first byte of the next frame is accepted no earlier than 12 cycles after the last `tx_eop` byte is on the pins.
- At 100M the same gap is 120 cycles.
- Reset values:
  - all outputs 0, including `txc_*` (clock stopped) and `tx_ready`;
  - `speed_q`=0 (1000M); phase=0; state=IDLE.
- Reset asserted mid-frame aborts the frame immediately. After release, no IFG is inserted.
- `tx_eop` together with `tx_valid`=0 is ignored.
- In DATA, an underrun takes priority; an `eop` in DROP ends the drop.

## Structure
- Package `rgmii_tx_pkg`:
  - state enum IDLE/DATA/ERR/DROP/IFG;
  - constants `SLOT_100`=10, `IFG_BYTES`=12, `SPEED_100`=1'b1.
- Sub-module `rgmii_tx_clkgen`: contains the phase counter, `slot_end` and the TXC pattern, with restart on speed change.
- The top level holds the FSM, byte register, IFG counter and output registers.

## Test plan
- **1000M, 64-byte frame**, `tx_valid` held high: `tx_ready`=1 throughout.
  - TX_EN high for exactly 64 cycles, starting one cycle after the first accept.
  - `txd_h`/`txd_l` match the byte nibbles.
  - 12 idle cycles before the next accept.
- **100M, frame 0x55,0xD5:**
  - `tx_ready` pulses only at phase 9.
  - TXD=5 for 10 cycles, then 5 for 5 cycles, then D for 5 cycles.
  - TXC toggles 5 high / 5 low half-cycles.
  - 120-cycle gap after the frame.
- **Underrun:** drop `tx_valid` after byte 10 at 1000M.
  - `tx_underrun` pulses once.
  - One slot with `txctl_h`=1, `txctl_l`=0.
  - Subsequent bytes are consumed with TX_EN=0 until `eop`, then IFG.
- **Speed toggle mid-frame** (1000M→100M at byte 5):
  - The frame finishes at 1000M and the IFG runs at 1000M.
  - The change takes effect at the next IDLE slot end, with phase restarting at 0.
- **Reset mid-frame at 100M:** all outputs 0 in the same cycle as reset assertion; after release, `speed_q`=0 and `tx_ready`=1 on the first cycle.

Source files
------------

// File: rtl/rgmii_tx_pkg.sv
// -----------------------------------------------------------------------------
// rgmii_tx_pkg
// Shared types, constants and helpers for the RGMII transmit adapter.
//   state_t     : transmit FSM states
//   SLOT_100    : sys_clk cycles per byte at 100M (two 25 MHz TXC periods)
//   IFG_BYTES   : idle byte slots forced after every frame
//   SPEED_100   : value of the speed select meaning 100M
//   PHASE_W     : width of the 100M phase counter
//   txc_pattern : DDR TXC (h,l) pair for a given speed and phase
//   map_txd     : DDR TXD nibble pair {h,l} for a given speed and half-slot
// -----------------------------------------------------------------------------
package rgmii_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        ERR,
        DROP,
        IFG
    } state_t;

    localparam int   SLOT_100  = 10;
    localparam int   IFG_BYTES = 12;
    localparam logic SPEED_100 = 1'b1;
    localparam int   PHASE_W   = 4;
    localparam int   HALF_100  = SLOT_100 / 2;

    // At 100M one TXC period spans five sys_clk cycles (ten half-cycles):
    // five high half-cycles followed by five low ones, repeated twice per slot.
    function automatic logic [1:0] txc_pattern(input logic speed,
                                               input logic [PHASE_W-1:0] phase);
        logic [PHASE_W-1:0] p;
        if (speed != SPEED_100) begin
            return 2'b10;
        end
        p = (phase >= PHASE_W'(HALF_100)) ? phase - PHASE_W'(HALF_100) : phase;
        return {(p < PHASE_W'(3)), (p < PHASE_W'(2))};
    endfunction

    // 1000M sends both nibbles in one cycle; 100M repeats the low nibble for
    // the first half of the slot and the high nibble for the second half.
    function automatic logic [7:0] map_txd(input logic speed,
                                           input logic low_half,
                                           input logic [7:0] b);
        if (speed == SPEED_100) begin
            return low_half ? {b[3:0], b[3:0]} : {b[7:4], b[7:4]};
        end
        return {b[3:0], b[7:4]};
    endfunction

endpackage

// File: rtl/rgmii_tx_clkgen.sv
// -----------------------------------------------------------------------------
// rgmii_tx_clkgen
// Byte-slot timing for the RGMII transmit adapter: latched speed, phase
// counter, slot_end strobe and the registered TXC pattern.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   speed_sel          : requested speed (1 = 100M, 0 = 1000M)
//   sample_en          : speed may be re-latched (FSM is idle)
//   slot_end           : last cycle of the current byte slot
//   speed_next         : speed value the latch takes at the next edge
//   phase_next         : phase value the counter takes at the next edge
//   txc_h, txc_l       : registered DDR inputs for the TXC pin
// -----------------------------------------------------------------------------
module rgmii_tx_clkgen #(
    parameter int SLOT_100 = rgmii_tx_pkg::SLOT_100
) (
    input  logic                             sys_clk,
    input  logic                             sys_rst_n,
    input  logic                             speed_sel,
    input  logic                             sample_en,
    output logic                             slot_end,
    output logic                             speed_next,
    output logic [rgmii_tx_pkg::PHASE_W-1:0] phase_next,
    output logic                             txc_h,
    output logic                             txc_l
);
    import rgmii_tx_pkg::PHASE_W, rgmii_tx_pkg::SPEED_100, rgmii_tx_pkg::txc_pattern;

    logic               speed_q_reg;
    logic [PHASE_W-1:0] phase_reg;
    logic               txc_h_reg;
    logic               txc_l_reg;
    logic [1:0]         txc_next;

    assign slot_end = (speed_q_reg == SPEED_100) ? (phase_reg == PHASE_W'(SLOT_100 - 1)) : 1'b1;

    always_comb begin
        speed_next = (sample_en && slot_end) ? speed_sel : speed_q_reg;
        // A speed change always starts a fresh slot at phase 0.
        if (speed_next != speed_q_reg) begin
            phase_next = '0;
        end else if (speed_q_reg == SPEED_100) begin
            phase_next = slot_end ? '0 : phase_reg + 1'b1;
        end else begin
            phase_next = '0;
        end
        txc_next = txc_pattern(speed_next, phase_next);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            speed_q_reg <= 1'b0;
            phase_reg   <= '0;
            txc_h_reg   <= 1'b0;
            txc_l_reg   <= 1'b0;
        end else begin
            speed_q_reg <= speed_next;
            phase_reg   <= phase_next;
            txc_h_reg   <= txc_next[1];
            txc_l_reg   <= txc_next[0];
        end
    end

    assign txc_h = txc_h_reg;
    assign txc_l = txc_l_reg;

endmodule

// File: rtl/rgmii_tx_adapter.sv
// -----------------------------------------------------------------------------
// rgmii_tx_adapter
// Formats a MAC byte stream into DDR register inputs for an RGMII transmitter
// at 100M or 1000M, enforcing the inter-frame gap and handling MAC underrun.
// Ports:
//   sys_clk, sys_rst_n   : 125 MHz clock, asynchronous active-low reset
//   SPEED_IS_100_1000    : speed select (1 = 100M, 0 = 1000M), sys_clk domain
//   tx_data/valid/eop    : MAC byte stream, eop marks the last byte
//   tx_ready             : byte taken when tx_valid & tx_ready
//   txd_h, txd_l         : TXD for rising / falling half-cycle
//   txctl_h, txctl_l     : TX_EN and TX_EN ^ TX_ER
//   txc_h, txc_l         : TXC pattern for the DDR output
//   tx_underrun          : one-cycle pulse when the MAC starves a frame
// -----------------------------------------------------------------------------
module rgmii_tx_adapter #(
    parameter int SLOT_100  = rgmii_tx_pkg::SLOT_100,
    parameter int IFG_BYTES = rgmii_tx_pkg::IFG_BYTES
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       SPEED_IS_100_1000,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_eop,
    output logic       tx_ready,
    output logic [3:0] txd_h,
    output logic [3:0] txd_l,
    output logic       txctl_h,
    output logic       txctl_l,
    output logic       txc_h,
    output logic       txc_l,
    output logic       tx_underrun
);
    import rgmii_tx_pkg::state_t, rgmii_tx_pkg::IDLE, rgmii_tx_pkg::DATA,
           rgmii_tx_pkg::ERR, rgmii_tx_pkg::DROP, rgmii_tx_pkg::IFG,
           rgmii_tx_pkg::PHASE_W, rgmii_tx_pkg::map_txd;

    localparam int IFG_W = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;

    state_t             state_reg;
    logic [IFG_W-1:0]   ifg_cnt_reg;
    logic [7:0]         byte_reg;
    logic [7:0]         byte_next;
    logic [7:0]         txd_next;
    logic [3:0]         txd_h_reg;
    logic [3:0]         txd_l_reg;
    logic               txctl_h_reg;
    logic               txctl_l_reg;
    logic               tx_underrun_reg;

    logic               slot_end;
    logic               speed_next;
    logic [PHASE_W-1:0] phase_next;
    logic               load_byte;
    logic               underrun;

    rgmii_tx_clkgen #(
        .SLOT_100 (SLOT_100)
    ) u_clkgen (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .speed_sel  (SPEED_IS_100_1000),
        .sample_en  (state_reg == IDLE),
        .slot_end   (slot_end),
        .speed_next (speed_next),
        .phase_next (phase_next),
        .txc_h      (txc_h),
        .txc_l      (txc_l)
    );

    // Gated by reset so the handshake reads 0 while the block is held.
    assign tx_ready = sys_rst_n && slot_end &&
                      (state_reg == IDLE || state_reg == DATA || state_reg == DROP);

    // Bytes taken in DROP are discarded, so only IDLE/DATA load the shifter.
    assign load_byte = tx_ready && tx_valid && (state_reg == IDLE || state_reg == DATA);
    assign underrun  = slot_end && (state_reg == DATA) && !tx_valid;

    // Pin values are computed from next-cycle phase/speed so that the
    // registered outputs line up with the phase counter.
    always_comb begin
        byte_next = byte_reg;
        if (slot_end) begin
            byte_next = load_byte ? tx_data : 8'h00;
        end
        txd_next = map_txd(speed_next, (phase_next < PHASE_W'(SLOT_100 / 2)), byte_next);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg       <= IDLE;
            ifg_cnt_reg     <= '0;
            byte_reg        <= 8'h00;
            txd_h_reg       <= 4'h0;
            txd_l_reg       <= 4'h0;
            txctl_h_reg     <= 1'b0;
            txctl_l_reg     <= 1'b0;
            tx_underrun_reg <= 1'b0;
        end else begin
            byte_reg        <= byte_next;
            txd_h_reg       <= txd_next[7:4];
            txd_l_reg       <= txd_next[3:0];
            tx_underrun_reg <= underrun;
            if (slot_end) begin
                // Data slot: EN=1, ER=0. Error slot: EN=1, ER=1 -> low half 0.
                txctl_h_reg <= load_byte || underrun;
                txctl_l_reg <= load_byte;
                case (state_reg)
                    IDLE: begin
                        if (load_byte) begin
                            state_reg   <= tx_eop ? IFG : DATA;
                            ifg_cnt_reg <= '0;
                        end
                    end
                    DATA: begin
                        if (underrun) begin
                            state_reg <= ERR;
                        end else if (tx_eop) begin
                            state_reg   <= IFG;
                            ifg_cnt_reg <= '0;
                        end
                    end
                    ERR: begin
                        state_reg <= DROP;
                    end
                    DROP: begin
                        if (tx_valid && tx_eop) begin
                            state_reg   <= IFG;
                            ifg_cnt_reg <= '0;
                        end
                    end
                    IFG: begin
                        // The first IFG slot still carries the eop byte; the
                        // final idle slot is spent in IDLE with tx_ready high.
                        if (ifg_cnt_reg == IFG_W'(IFG_BYTES - 1)) begin
                            state_reg <= IDLE;
                        end else begin
                            ifg_cnt_reg <= ifg_cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign txd_h       = txd_h_reg;
    assign txd_l       = txd_l_reg;
    assign txctl_h     = txctl_h_reg;
    assign txctl_l     = txctl_l_reg;
    assign tx_underrun = tx_underrun_reg;

endmodule

// File: tb/tb_rgmii_tx_adapter.sv
// -----------------------------------------------------------------------------
// tb_rgmii_tx_adapter
// Directed bench for rgmii_tx_adapter: reset, 1000M frame, 100M frame,
// underrun, speed change during a frame and reset during a 100M frame.
// -----------------------------------------------------------------------------
module tb_rgmii_tx_adapter;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       speed;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_eop;
    logic       tx_ready;
    logic [3:0] txd_h;
    logic [3:0] txd_l;
    logic       txctl_h;
    logic       txctl_l;
    logic       txc_h;
    logic       txc_l;
    logic       tx_underrun;

    int errors = 0;
    int checks = 0;

    rgmii_tx_adapter dut (
        .sys_clk           (sys_clk),
        .sys_rst_n         (sys_rst_n),
        .SPEED_IS_100_1000 (speed),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_eop            (tx_eop),
        .tx_ready          (tx_ready),
        .txd_h             (txd_h),
        .txd_l             (txd_l),
        .txctl_h           (txctl_h),
        .txctl_l           (txctl_l),
        .txc_h             (txc_h),
        .txc_l             (txc_l),
        .tx_underrun       (tx_underrun)
    );

    initial begin
        sys_clk = 1'b0;
        forever #4 sys_clk = ~sys_clk;
    end

    // Advance one clock and land 1 ns after the active edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        speed     = 1'b0;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        tx_eop    = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if ({txd_h, txd_l, txctl_h, txctl_l, txc_h, txc_l, tx_ready, tx_underrun} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0000",
                     {txd_h, txd_l, txctl_h, txctl_l, txc_h, txc_l, tx_ready, tx_underrun});
        end
        sys_rst_n = 1'b1;
        #1;
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", tx_ready);
        end
        step();
        checks++;
        if ({txc_h, txc_l} !== 2'b10) begin
            errors++;
            $display("FAIL reset_txc_1000: got %b expected 10", {txc_h, txc_l});
        end
        $display("reset: released, 1000M idle");
    endtask

    task automatic test_1000_frame();
        logic [7:0] b;
        int bad_rdy;
        bad_rdy = 0;
        checks++;
        if ({txctl_h, tx_ready} !== 2'b01) begin
            errors++;
            $display("FAIL g_pre_frame: got en/rdy %b expected 01", {txctl_h, tx_ready});
        end
        for (int i = 0; i < 64; i++) begin
            b = 8'(i * 7 + 3);
            if (tx_ready !== 1'b1) bad_rdy++;
            tx_valid = 1'b1;
            tx_data  = b;
            tx_eop   = (i == 63);
            step();
            checks++;
            if ({txctl_h, txctl_l, txd_h, txd_l} !== {2'b11, b[3:0], b[7:4]}) begin
                errors++;
                $display("FAIL g_byte%0d: got ctl=%b txd=%h/%h expected ctl=11 txd=%h/%h",
                         i, {txctl_h, txctl_l}, txd_h, txd_l, b[3:0], b[7:4]);
            end
        end
        tx_valid = 1'b0;
        tx_eop   = 1'b0;
        checks++;
        if (bad_rdy !== 0) begin
            errors++;
            $display("FAIL g_ready_held: got %0d not-ready slots expected 0", bad_rdy);
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if ({txctl_h, tx_ready} !== {1'b0, (k == 12)}) begin
                errors++;
                $display("FAIL g_ifg%0d: got en/rdy %b expected %b",
                         k, {txctl_h, tx_ready}, {1'b0, (k == 12)});
            end
        end
        $display("1000M frame: 64 bytes sent, 12-cycle gap");
    endtask

    task automatic test_100_frame();
        int n;
        int bad;
        int p;
        logic [3:0] nib;
        speed = 1'b1;
        step();
        checks++;
        if ({txc_h, txc_l, tx_ready} !== 3'b110) begin
            errors++;
            $display("FAIL m_latch: got txc/rdy %b expected 110", {txc_h, txc_l, tx_ready});
        end
        n = 0;
        while (tx_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n !== 9) begin
            errors++;
            $display("FAIL m_ready_phase: got ready after %0d cycles expected 9", n);
        end
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        tx_eop   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            p = c % 5;
            checks++;
            if ({txctl_h, txctl_l, txd_h, txd_l, txc_h, txc_l, tx_ready} !==
                {2'b11, 4'h5, 4'h5, (p < 3), (p < 2), (c == 9)}) begin
                errors++;
                $display("FAIL m_b55_c%0d: got ctl=%b txd=%h/%h txc=%b rdy=%b",
                         c, {txctl_h, txctl_l}, txd_h, txd_l, {txc_h, txc_l}, tx_ready);
            end
        end
        tx_data = 8'hD5;
        tx_eop  = 1'b1;
        for (int d = 0; d < 10; d++) begin
            step();
            nib = (d < 5) ? 4'h5 : 4'hD;
            checks++;
            if ({txctl_h, txd_h, txd_l, tx_ready} !== {1'b1, nib, nib, 1'b0}) begin
                errors++;
                $display("FAIL m_bd5_c%0d: got en=%b txd=%h/%h rdy=%b expected 1 %h/%h 0",
                         d, txctl_h, txd_h, txd_l, tx_ready, nib, nib);
            end
            tx_valid = 1'b0;
            tx_eop   = 1'b0;
        end
        n   = 0;
        bad = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            step();
            n++;
            if (txctl_h !== 1'b0) bad++;
        end
        checks++;
        if (n !== 120 || bad !== 0) begin
            errors++;
            $display("FAIL m_gap: got %0d cycles (%0d with TX_EN) expected 120 (0)", n, bad);
        end
        speed = 1'b0;
        step();
        checks++;
        if ({txc_h, txc_l, tx_ready} !== 3'b101) begin
            errors++;
            $display("FAIL m_back_1000: got txc/rdy %b expected 101", {txc_h, txc_l, tx_ready});
        end
        $display("100M frame: 55 D5 sent, gap %0d cycles", n);
    endtask

    task automatic test_underrun();
        int n;
        int bad;
        for (int i = 0; i < 10; i++) begin
            tx_valid = 1'b1;
            tx_data  = 8'hA0 + 8'(i);
            tx_eop   = 1'b0;
            step();
        end
        checks++;
        if ({txctl_h, txd_h, txd_l} !== {1'b1, 4'h9, 4'hA}) begin
            errors++;
            $display("FAIL u_byte10: got en=%b txd=%h/%h expected 1 9/a", txctl_h, txd_h, txd_l);
        end
        tx_valid = 1'b0;
        step();
        checks++;
        if ({tx_underrun, txctl_h, txctl_l, txd_h, txd_l, tx_ready} !== {3'b110, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL u_err_slot: got urun=%b ctl=%b txd=%h/%h rdy=%b expected 1 10 0/0 0",
                     tx_underrun, {txctl_h, txctl_l}, txd_h, txd_l, tx_ready);
        end
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        step();
        checks++;
        if ({tx_underrun, txctl_h, txctl_l, tx_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL u_drop_entry: got urun/ctl/rdy %b expected 0001",
                     {tx_underrun, txctl_h, txctl_l, tx_ready});
        end
        bad = 0;
        for (int j = 0; j < 3; j++) begin
            tx_data = 8'h20 + 8'(j);
            tx_eop  = (j == 2);
            step();
            if (txctl_h !== 1'b0 || tx_underrun !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL u_drop: got %0d active slots rdy=%b expected 0 rdy=0", bad, tx_ready);
        end
        tx_valid = 1'b0;
        tx_eop   = 1'b0;
        n = 0;
        while (tx_ready !== 1'b1 && n < 50) begin
            step();
            n++;
            if (txctl_h !== 1'b0 || tx_underrun !== 1'b0) bad++;
        end
        checks++;
        if (n !== 12 || bad !== 0) begin
            errors++;
            $display("FAIL u_ifg: got %0d cycles (%0d active) expected 12 (0)", n, bad);
        end
        $display("underrun: error slot sent, frame dropped, gap %0d cycles", n);
    endtask

    task automatic test_speed_toggle();
        logic [7:0] b;
        int n;
        int bad;
        for (int i = 0; i < 8; i++) begin
            b        = 8'h60 + 8'(i);
            tx_valid = 1'b1;
            tx_data  = b;
            tx_eop   = (i == 7);
            if (i == 4) speed = 1'b1;
            step();
            checks++;
            if ({txctl_h, txd_h, txd_l, txc_h, txc_l} !== {1'b1, b[3:0], b[7:4], 2'b10}) begin
                errors++;
                $display("FAIL s_byte%0d: got en=%b txd=%h/%h txc=%b expected 1 %h/%h 10",
                         i, txctl_h, txd_h, txd_l, {txc_h, txc_l}, b[3:0], b[7:4]);
            end
        end
        tx_valid = 1'b0;
        tx_eop   = 1'b0;
        n   = 0;
        bad = 0;
        while (tx_ready !== 1'b1 && n < 50) begin
            step();
            n++;
            if ({txc_h, txc_l, txctl_h} !== 3'b100) bad++;
        end
        checks++;
        if (n !== 12 || bad !== 0) begin
            errors++;
            $display("FAIL s_ifg_1000: got %0d cycles (%0d off-pattern) expected 12 (0)", n, bad);
        end
        step();
        checks++;
        if ({txc_h, txc_l, tx_ready} !== 3'b110) begin
            errors++;
            $display("FAIL s_latch: got txc/rdy %b expected 110", {txc_h, txc_l, tx_ready});
        end
        n = 0;
        while (tx_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n !== 9) begin
            errors++;
            $display("FAIL s_phase_restart: got ready after %0d cycles expected 9", n);
        end
        $display("speed toggle: frame and gap at 1000M, 100M from next idle slot");
    endtask

    task automatic test_reset_midframe();
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        tx_eop   = 1'b0;
        step();
        checks++;
        if ({txctl_h, txd_h, txd_l} !== {1'b1, 4'hC, 4'hC}) begin
            errors++;
            $display("FAIL r_first_nibble: got en=%b txd=%h/%h expected 1 c/c", txctl_h, txd_h, txd_l);
        end
        tx_valid = 1'b0;
        step();
        step();
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({txd_h, txd_l, txctl_h, txctl_l, txc_h, txc_l, tx_ready, tx_underrun} !== 14'h0) begin
            errors++;
            $display("FAIL r_async_clear: got %h expected 0000",
                     {txd_h, txd_l, txctl_h, txctl_l, txc_h, txc_l, tx_ready, tx_underrun});
        end
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        #1;
        checks++;
        if ({tx_ready, txctl_h} !== 2'b10) begin
            errors++;
            $display("FAIL r_release: got rdy/en %b expected 10", {tx_ready, txctl_h});
        end
        step();
        checks++;
        if ({txc_h, txc_l, tx_ready, txctl_h} !== 4'b1100) begin
            errors++;
            $display("FAIL r_relatch: got txc/rdy/en %b expected 1100",
                     {txc_h, txc_l, tx_ready, txctl_h});
        end
        $display("reset mid-frame: outputs cleared, no gap after release");
    endtask

    initial begin
        test_reset();
        test_1000_frame();
        test_100_frame();
        test_underrun();
        test_speed_toggle();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
